vram_arbiter: RTL
=================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDRW, default 15: video RAM address width in bits.
REQ-002 Parameter DATAW, default 16: video RAM data width in bits (RGB565 pixel).
REQ-003 Parameter STARVE_MAX, default 8: writer wait cycles before a forced write slot; legal range 1..255.
REQ-004 PCLK  input  1  pixel clock (25.2 MHz); the only clock; all state changes on rising edge.
REQ-005 RST_PCLK  input  1  reset, synchronous, active-high.
REQ-006 RD_REQ  input  1  display fetch request; held until RD_GNT seen.
REQ-007 RD_ADDR  input  ADDRW  display fetch address; stable while RD_REQ high.
REQ-008 RD_GNT  output  1  registered one-cycle read grant.
REQ-009 RD_VALID  output  1  registered one-cycle read-data strobe.
REQ-010 RD_DATA  output  DATAW  read data, valid only when RD_VALID high.
REQ-011 WR_REQ  input  1  draw-engine write request; held until WR_ACK seen.
REQ-012 WR_ADDR  input  ADDRW  write address; stable while WR_REQ high.
REQ-013 WR_DATA  input  DATAW  write data; stable while WR_REQ high.
REQ-014 WR_ACK  output  1  registered one-cycle write grant/completion.
REQ-015 MEM_CE  output  1  RAM clock enable, registered.
REQ-016 MEM_WE  output  1  RAM write enable, registered.
REQ-017 MEM_ADDR  output  ADDRW  RAM address, registered.
REQ-018 MEM_WDATA  output  DATAW  RAM write data, registered.
REQ-019 MEM_RDATA  input  DATAW  RAM read data, valid one cycle after a read access (BSRAM, 1-cycle latency).

Function
REQ-020 At most one RAM access (read or write) SHALL issue per cycle.
REQ-021 Slot FSM states: IDLE (no access), RD (read issued), WR (write issued); next state decided each cycle from inputs sampled at the edge.
REQ-022 Requests sampled at edge N SHALL produce the access on MEM_* and the matching RD_GNT or WR_ACK during cycle N+1.
REQ-023 Arbitration: RD_REQ wins over WR_REQ unless the starvation counter equals STARVE_MAX, in which case WR wins.
REQ-024 Starvation counter (8-bit): increments each cycle WR_REQ high and not granted; saturates at STARVE_MAX; clears to 0 on a write grant or when WR_REQ low.
REQ-025 Neither request high -> IDLE: MEM_CE=0, MEM_WE=0; MEM_ADDR/MEM_WDATA hold last value.
REQ-026 RD state: MEM_CE=1, MEM_WE=0, MEM_ADDR=RD_ADDR, RD_GNT=1.
REQ-027 WR state: MEM_CE=1, MEM_WE=1, MEM_ADDR=WR_ADDR, MEM_WDATA=WR_DATA, WR_ACK=1.
REQ-028 Read data: RD_DATA captures MEM_RDATA the cycle after RD; RD_VALID=1 in cycle N+3 for a request sampled at edge N (2 cycles after RD_GNT).
REQ-029 A request still high at the edge ending its grant cycle SHALL be a new request; back-to-back reads sustain one access per cycle with RD_VALID in order, one per grant.
REQ-030 RD_DATA holds its value while RD_VALID low.
REQ-031 Requester deasserting before grant: request withdrawn, no access, no grant.
REQ-032 Read pipeline depth 2: every RD grant yields exactly one RD_VALID, none lost or duplicated, including during forced write slots.

Reset
REQ-033 While RST_PCLK high at an edge: FSM to IDLE; starvation counter 0; RD_GNT, RD_VALID, WR_ACK, MEM_CE, MEM_WE = 0; MEM_ADDR, MEM_WDATA, RD_DATA = 0.
REQ-034 Reset mid-operation SHALL discard in-flight reads: no RD_VALID for grants preceding the reset edge.
REQ-035 First access may issue in cycle 2 after RST_PCLK deasserts (request sampled at the first edge with reset low).

Verification
REQ-036 Single read: RD_REQ at edge 0, RD_ADDR=0x0123, RAM holds 0xF800 -> cycle 1 RD_GNT=1, MEM_ADDR=0x0123, MEM_WE=0; cycle 3 RD_VALID=1, RD_DATA=0xF800.
REQ-037 Single write: WR_REQ, WR_ADDR=0x0040, WR_DATA=0x07E0 -> next cycle WR_ACK=1, MEM_WE=1, MEM_ADDR=0x0040, MEM_WDATA=0x07E0; readback returns 0x07E0.
REQ-038 Starvation: RD_REQ held continuously, WR_REQ held, STARVE_MAX=8 -> 8 read grants, then exactly one WR_ACK, then reads resume; RD_VALID count equals RD_GNT count.
REQ-039 Burst: RD_REQ held 16 cycles, addresses 0..15 -> 16 consecutive RD_GNT, 16 consecutive RD_VALID in address order, 2 cycles behind grants.
REQ-040 Reset mid-burst: RST_PCLK high one cycle during burst -> all outputs 0 next cycle, no RD_VALID for pre-reset grants, counter 0.
REQ-041 Idle: no requests for 100 cycles -> MEM_CE, MEM_WE, RD_GNT, WR_ACK, RD_VALID remain 0.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// ---------------------------------------------------------------------------
// vram_arbiter_if
// Bundles every signal between the video RAM arbiter, its two requesters
// (display fetch and draw engine) and the single-port block RAM.
//
// Handshake semantics (both requesters):
//   A requester raises RD_REQ / WR_REQ with its address (and write data)
//   stable and holds them until it sees RD_GNT / WR_ACK. The grant is a
//   one-cycle registered pulse. A request still high at the rising edge that
//   ends the grant cycle counts as a new request, so holding REQ high
//   requests one access per cycle. Dropping REQ before a grant withdraws it.
//   RD_VALID is a one-cycle strobe, exactly one per read grant, arriving two
//   cycles after that grant; RD_DATA is meaningful only while it is high.
//
// Modports:
//   slave  - the arbiter (receives requests and MEM_RDATA, drives the rest)
//   master - the requesters plus the RAM (testbench side)
//   dbg_state / dbg_starve expose the slot FSM state and starvation counter.
// ---------------------------------------------------------------------------
interface vram_arbiter_if #(
    parameter int ADDRW = 15,
    parameter int DATAW = 16
);
    logic             RD_REQ;
    logic [ADDRW-1:0] RD_ADDR;
    logic             RD_GNT;
    logic             RD_VALID;
    logic [DATAW-1:0] RD_DATA;

    logic             WR_REQ;
    logic [ADDRW-1:0] WR_ADDR;
    logic [DATAW-1:0] WR_DATA;
    logic             WR_ACK;

    logic             MEM_CE;
    logic             MEM_WE;
    logic [ADDRW-1:0] MEM_ADDR;
    logic [DATAW-1:0] MEM_WDATA;
    logic [DATAW-1:0] MEM_RDATA;

    logic [1:0]       dbg_state;
    logic [7:0]       dbg_starve;

    modport slave (
        input  RD_REQ, RD_ADDR, WR_REQ, WR_ADDR, WR_DATA, MEM_RDATA,
        output RD_GNT, RD_VALID, RD_DATA, WR_ACK,
        output MEM_CE, MEM_WE, MEM_ADDR, MEM_WDATA,
        output dbg_state, dbg_starve
    );

    modport master (
        output RD_REQ, RD_ADDR, WR_REQ, WR_ADDR, WR_DATA, MEM_RDATA,
        input  RD_GNT, RD_VALID, RD_DATA, WR_ACK,
        input  MEM_CE, MEM_WE, MEM_ADDR, MEM_WDATA,
        input  dbg_state, dbg_starve
    );
endinterface

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
// Shares one single-port video RAM (1-cycle read latency) between the
// display fetch (reads, normally higher priority) and the draw engine
// (writes). One access per cycle. The writer is guaranteed a slot after it
// has waited STARVE_MAX cycles.
//
// Ports:
//   PCLK      - pixel clock, all state changes on its rising edge
//   RST_PCLK  - synchronous active-high reset
//   bus       - vram_arbiter_if.slave: request/grant, read return, RAM port
//               and debug view of the slot FSM / starvation counter
// ---------------------------------------------------------------------------
module vram_arbiter #(
    parameter int ADDRW      = 15,
    parameter int DATAW      = 16,
    parameter int STARVE_MAX = 8
) (
    input  logic          PCLK,
    input  logic          RST_PCLK,
    vram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    state_t           state, state_next;
    logic [7:0]       starve_cnt, starve_next;

    logic             rd_gnt_q;
    logic             wr_ack_q;
    logic             mem_ce_q;
    logic             mem_we_q;
    logic [ADDRW-1:0] mem_addr_q;
    logic [DATAW-1:0] mem_wdata_q;
    logic             rd_pend_q;
    logic             rd_valid_q;
    logic [DATAW-1:0] rd_data_q;

    // Slot decision for the next cycle, taken from the requests present at
    // this edge. Reads win unless the writer has waited its full budget.
    always_comb begin
        state_next  = S_IDLE;
        starve_next = starve_cnt;

        if (bus.RD_REQ && !(bus.WR_REQ && starve_cnt == STARVE_LIM)) begin
            state_next = S_RD;
        end else if (bus.WR_REQ) begin
            state_next = S_WR;
        end

        if (!bus.WR_REQ || state_next == S_WR) begin
            starve_next = '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_next = starve_cnt + 8'd1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (RST_PCLK) begin
            state      <= S_IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end

    // Registered RAM port and grants, loaded from the same decision as the
    // state register so they always agree with it.
    always_ff @(posedge PCLK) begin
        if (RST_PCLK) begin
            rd_gnt_q    <= 1'b0;
            wr_ack_q    <= 1'b0;
            mem_ce_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            rd_gnt_q <= (state_next == S_RD);
            wr_ack_q <= (state_next == S_WR);
            mem_ce_q <= (state_next != S_IDLE);
            mem_we_q <= (state_next == S_WR);
            case (state_next)
                S_RD: mem_addr_q <= bus.RD_ADDR;
                S_WR: begin
                    mem_addr_q  <= bus.WR_ADDR;
                    mem_wdata_q <= bus.WR_DATA;
                end
                default: ;  // idle: address and write data hold
            endcase
        end
    end

    // Read return pipeline: the RAM samples the address at the end of the
    // grant cycle, presents data the cycle after, and RD_DATA captures it at
    // the following edge. Reset flushes anything in flight.
    always_ff @(posedge PCLK) begin
        if (RST_PCLK) begin
            rd_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_pend_q  <= rd_gnt_q;
            rd_valid_q <= rd_pend_q;
            if (rd_pend_q) begin
                rd_data_q <= bus.MEM_RDATA;
            end
        end
    end

    assign bus.RD_GNT     = rd_gnt_q;
    assign bus.WR_ACK     = wr_ack_q;
    assign bus.RD_VALID   = rd_valid_q;
    assign bus.RD_DATA    = rd_data_q;
    assign bus.MEM_CE     = mem_ce_q;
    assign bus.MEM_WE     = mem_we_q;
    assign bus.MEM_ADDR   = mem_addr_q;
    assign bus.MEM_WDATA  = mem_wdata_q;
    assign bus.dbg_state  = state;
    assign bus.dbg_starve = starve_cnt;

endmodule
